// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared op/state encodings and operand-sign helpers for alu_muldiv.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_e;

  function automatic logic is_div_op(input md_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem_op(input md_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic a_is_signed(input md_op_e op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic b_is_signed(input md_op_e op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_iter_core.sv
// ============================================================================
// Module      : muldiv_iter_core
// Description : Unsigned one-bit-per-cycle shift-add multiplier / restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_iter_core #(
  parameter int DW    = 32,
  parameter int CNT_W = $clog2(DW) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          is_div_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic          done_o,
  output logic [DW-1:0] hi_nxt_o,
  output logic [DW-1:0] lo_nxt_o
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(DW - 1);

  logic             r_busy;
  logic             r_is_div;
  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]    r_hi;
  logic [DW-1:0]    r_lo;
  logic [DW-1:0]    r_b;

  logic [DW:0]      w_sum;
  logic [DW:0]      w_shift;
  logic [DW:0]      w_diff;
  logic [DW-1:0]    w_mul_hi;
  logic [DW-1:0]    w_mul_lo;
  logic [DW-1:0]    w_div_hi;
  logic [DW-1:0]    w_div_lo;

  // hi:lo is the running product (mul) or partial remainder:dividend/quotient (div)
  always_comb begin
    w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_mul_hi = w_sum[DW:1];
    w_mul_lo = {w_sum[0], r_lo[DW-1:1]};

    w_shift  = {r_hi, r_lo[DW-1]};
    w_diff   = w_shift - {1'b0, r_b};
    w_div_hi = w_diff[DW] ? w_shift[DW-1:0] : w_diff[DW-1:0];
    w_div_lo = {r_lo[DW-2:0], ~w_diff[DW]};
  end

  assign hi_nxt_o = r_is_div ? w_div_hi : w_mul_hi;
  assign lo_nxt_o = r_is_div ? w_div_lo : w_mul_lo;
  assign done_o   = r_busy && (r_cnt == c_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_is_div <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
    end else if (abort_i) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (start_i) begin
      r_busy   <= 1'b1;
      r_is_div <= is_div_i;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= a_i;
      r_b      <= b_i;
    end else if (r_busy) begin
      r_hi   <= hi_nxt_o;
      r_lo   <= lo_nxt_o;
      r_cnt  <= done_o ? '0 : r_cnt + 1'b1;
      r_busy <= !done_o;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_muldiv.sv
// ============================================================================
// Module      : alu_muldiv
// Description : Multi-cycle RV32M execute unit: handshake, FSM, signs, fast path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_muldiv
  import muldiv_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = $clog2(DW) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [2:0]    op_i,
  input  logic [DW-1:0] operand_a_i,
  input  logic [DW-1:0] operand_b_i,
  input  logic          flush_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [DW-1:0] result_o,
  output logic          busy_o
);

  localparam logic [DW-1:0] c_min = {1'b1, {(DW-1){1'b0}}};

  md_state_e       r_state;
  md_state_e       w_state_nxt;
  md_op_e          r_op;
  logic            r_neg;
  logic [DW-1:0]   r_result;

  md_op_e          w_op;
  logic            w_accept;
  logic            w_sa;
  logic            w_sb;
  logic            w_neg;
  logic [DW-1:0]   w_mag_a;
  logic [DW-1:0]   w_mag_b;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_fast;
  logic [DW-1:0]   w_fast_result;

  logic            w_core_done;
  logic [DW-1:0]   w_hi_nxt;
  logic [DW-1:0]   w_lo_nxt;
  logic [2*DW-1:0] w_prod;
  logic [DW-1:0]   w_quo;
  logic [DW-1:0]   w_rem;
  logic [DW-1:0]   w_calc_result;

  assign w_op     = md_op_e'(op_i);
  assign w_accept = valid_i && (r_state == IDLE) && !flush_i;

  assign w_sa    = a_is_signed(w_op) & operand_a_i[DW-1];
  assign w_sb    = b_is_signed(w_op) & operand_b_i[DW-1];
  assign w_mag_a = w_sa ? (~operand_a_i + 1'b1) : operand_a_i;
  assign w_mag_b = w_sb ? (~operand_b_i + 1'b1) : operand_b_i;
  // Remainder follows the dividend sign; product and quotient follow sa^sb
  assign w_neg   = is_rem_op(w_op) ? w_sa : (w_sa ^ w_sb);

  assign w_div_zero = is_div_op(w_op) && (operand_b_i == '0);
  assign w_ovf      = ((w_op == MD_DIV) || (w_op == MD_REM)) &&
                      (operand_a_i == c_min) && (operand_b_i == '1);
  assign w_fast     = w_div_zero || w_ovf;

  always_comb begin
    w_fast_result = '0;
    if (w_div_zero) begin
      w_fast_result = is_rem_op(w_op) ? operand_a_i : '1;
    end else if (w_ovf) begin
      w_fast_result = is_rem_op(w_op) ? '0 : c_min;
    end
  end

  muldiv_iter_core #(
    .DW    (DW),
    .CNT_W (CNT_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .start_i  (w_accept && !w_fast),
    .abort_i  (flush_i),
    .is_div_i (is_div_op(w_op)),
    .a_i      (w_mag_a),
    .b_i      (w_mag_b),
    .done_o   (w_core_done),
    .hi_nxt_o (w_hi_nxt),
    .lo_nxt_o (w_lo_nxt)
  );

  // Final iteration's values are sign-corrected and registered in the same cycle
  assign w_prod = r_neg ? (~{w_hi_nxt, w_lo_nxt} + 1'b1) : {w_hi_nxt, w_lo_nxt};
  assign w_quo  = r_neg ? (~w_lo_nxt + 1'b1) : w_lo_nxt;
  assign w_rem  = r_neg ? (~w_hi_nxt + 1'b1) : w_hi_nxt;

  always_comb begin
    w_calc_result = '0;
    case (r_op)
      MD_MUL:                         w_calc_result = w_prod[DW-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:   w_calc_result = w_prod[2*DW-1:DW];
      MD_DIV, MD_DIVU:                w_calc_result = w_quo;
      MD_REM, MD_REMU:                w_calc_result = w_rem;
      default:                        w_calc_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_fast ? DONE : CALC;
      CALC:    if (w_core_done) w_state_nxt = DONE;
      DONE:    if (ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush_i) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= MD_MUL;
      r_neg    <= 1'b0;
      r_result <= '0;
    end else if (!flush_i) begin
      if (w_accept) begin
        r_op  <= w_op;
        r_neg <= w_neg;
        if (w_fast) begin
          r_result <= w_fast_result;
        end
      end else if ((r_state == CALC) && w_core_done) begin
        r_result <= w_calc_result;
      end
    end
  end

  assign result_o = r_result;
  assign valid_o  = (r_state == DONE);
  assign ready_o  = (r_state == IDLE);
  assign busy_o   = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_muldiv.sv
// ============================================================================
// Module      : tb_alu_muldiv
// Description : Self-checking bench for alu_muldiv (vector table + corner sequences).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_muldiv;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [2:0]    op_i = '0;
  logic [DW-1:0] operand_a_i = '0;
  logic [DW-1:0] operand_b_i = '0;
  logic          flush_i = 1'b0;
  logic          valid_o;
  logic          ready_i = 1'b1;
  logic [DW-1:0] result_o;
  logic          busy_o;

  alu_muldiv #(.DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .op_i        (op_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .flush_i     (flush_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .result_o    (result_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          fast;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  logic [31:0] sb_q[$];
  vec_t        vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one request, measures posedges from accept (inclusive) to valid_o,
  // optionally holds ready_i low for 'hold' cycles, then retires the result.
  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit fast,
                       input int hold);
    int          n;
    bit          busy_dropped;
    logic [31:0] want;
    @(negedge clk);
    check({name, " ready_o"}, {31'b0, ready_o}, 32'd1);
    ready_i     = (hold == 0);
    op_i        = op;
    operand_a_i = a;
    operand_b_i = b;
    valid_i     = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    n = 1;
    busy_dropped = 1'b0;
    while (!valid_o && n < 200) begin
      if (!busy_o) busy_dropped = 1'b1;
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, n, fast ? 32'd1 : 32'(DW + 1));
    check({name, " busy held"}, {31'b0, busy_dropped}, 32'd0);
    check({name, " valid_o"}, {31'b0, valid_o}, 32'd1);
    want = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEADBEEF;
    check({name, " result"}, result_o, want);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, " hold valid"}, {31'b0, valid_o}, 32'd1);
      check({name, " hold result"}, result_o, want);
    end
    ready_i = 1'b1;
    @(negedge clk);
    check({name, " valid drop"}, {31'b0, valid_o}, 32'd0);
  endtask

  initial begin
    int  n;
    bit  seen;

    vecs[0]  = '{3'b000, 32'd34,        32'd3,         32'd102,       1'b0};
    vecs[1]  = '{3'b001, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000,  1'b0};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  1'b0};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0};
    vecs[4]  = '{3'b100, 32'd100,       32'd5,         32'd20,        1'b0};
    vecs[5]  = '{3'b110, 32'd1111,      32'd2,         32'd1,         1'b0};
    vecs[6]  = '{3'b100, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  1'b0};
    vecs[7]  = '{3'b110, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  1'b0};
    vecs[8]  = '{3'b101, 32'd9999,      32'd0,         32'hFFFFFFFF,  1'b1};
    vecs[9]  = '{3'b111, 32'd9999,      32'd0,         32'd9999,      1'b1};
    vecs[10] = '{3'b100, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1'b1};
    vecs[11] = '{3'b110, 32'h80000000,  32'hFFFFFFFF,  32'h00000000,  1'b1};
    vecs[12] = '{3'b000, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  1'b0};
    vecs[13] = '{3'b001, 32'hFFFFFFFD,  32'd5,         32'hFFFFFFFF,  1'b0};
    vecs[14] = '{3'b101, 32'hFFFFFFFF,  32'h10,        32'h0FFFFFFF,  1'b0};
    vecs[15] = '{3'b111, 32'hFFFFFFFF,  32'h10,        32'h0000000F,  1'b0};
    vecs[16] = '{3'b100, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  1'b0};
    vecs[17] = '{3'b110, 32'd7,         32'hFFFFFFFE,  32'd1,         1'b0};
    vecs[18] = '{3'b100, 32'd5,         32'd0,         32'hFFFFFFFF,  1'b1};
    vecs[19] = '{3'b110, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFB,  1'b1};

    repeat (2) @(negedge clk);
    check("reset result_o", result_o, 32'd0);
    check("reset valid_o", {31'b0, valid_o}, 32'd0);
    check("reset busy_o", {31'b0, busy_o}, 32'd0);
    check("reset ready_o", {31'b0, ready_o}, 32'd1);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].exp, vecs[i].fast, 0);
    end

    do_op("backpressure", 3'b100, 32'd100, 32'd5, 32'd20, 1'b0, 5);
    do_op("backpressure fast", 3'b101, 32'd1, 32'd0, 32'hFFFFFFFF, 1'b1, 5);

    // flush beats a simultaneous request in IDLE
    @(negedge clk);
    op_i = 3'b000; operand_a_i = 32'd2; operand_b_i = 32'd3;
    valid_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0;
    check("flush vs accept busy_o", {31'b0, busy_o}, 32'd0);

    // flush during iteration 10 of a DIV
    @(negedge clk);
    op_i = 3'b100; operand_a_i = 32'h12345678; operand_b_i = 32'd3; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (9) @(negedge clk);
    check("flush pre busy_o", {31'b0, busy_o}, 32'd1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush busy_o", {31'b0, busy_o}, 32'd0);
    check("flush ready_o", {31'b0, ready_o}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (valid_o) seen = 1'b1;
      @(negedge clk);
    end
    check("flush no valid_o", {31'b0, seen}, 32'd0);

    // reset pulse mid-MUL
    op_i = 3'b000; operand_a_i = 32'd7; operand_b_i = 32'd9; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid rst result_o", result_o, 32'd0);
    check("mid rst valid_o", {31'b0, valid_o}, 32'd0);
    check("mid rst busy_o", {31'b0, busy_o}, 32'd0);
    check("mid rst ready_o", {31'b0, ready_o}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_o) n++;
      @(negedge clk);
    end
    check("mid rst no valid_o", n, 32'd0);

    do_op("after rst", 3'b000, 32'd34, 32'd3, 32'd102, 1'b0, 0);
    do_op("after rst div", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 0);

    check("scoreboard empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
